// File: rtl/data_mem_responder.sv
// data_mem_responder: word-organised data memory behind a Req/Ack handshake.
// A request is accepted in IDLE, optionally held for WAIT_STATES cycles, then
// completed with a one-cycle Ack. Misaligned or out-of-range addresses are
// rejected through ERR with Addr_Error=1.
//
// Ports:
//   Clock      - system clock, rising edge active
//   Reset      - asynchronous active-high reset (array contents are kept)
//   Req        - request valid, held by the requester until Ack
//   Write      - 1 = store, 0 = load (sampled with Req)
//   Addr       - byte address
//   Write_Data - store data
//   Ack        - one-cycle completion strobe
//   Read_Data  - load result, valid with Ack and held afterwards
//   Busy       - high whenever the responder is not idle
//   Addr_Error - valid with Ack, 1 = request rejected
module data_mem_responder #(
    parameter int unsigned ADDR_WIDTH  = 13,
    parameter int unsigned DEPTH_WORDS = 2048,
    parameter int unsigned WAIT_STATES = 2
) (
    input  logic                  Clock,
    input  logic                  Reset,
    input  logic                  Req,
    input  logic                  Write,
    input  logic [ADDR_WIDTH-1:0] Addr,
    input  logic [31:0]           Write_Data,
    output logic                  Ack,
    output logic [31:0]           Read_Data,
    output logic                  Busy,
    output logic                  Addr_Error
);

    localparam int unsigned IdxW  = ADDR_WIDTH - 2;
    localparam int unsigned MemAw = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;

    typedef enum logic [1:0] {StIdle, StWait, StResp, StErr} state_e;

    state_e            state_q, state_d;
    logic [3:0]        cnt_q, cnt_d;
    logic              wr_q, wr_d;
    logic [IdxW-1:0]   idx_q, idx_d;
    logic [31:0]       wdata_q, wdata_d;
    logic              ack_q, ack_d;
    logic              busy_q, busy_d;
    logic              err_q, err_d;
    logic [31:0]       rdata_q, rdata_d;

    // Array starts at zero and is deliberately not cleared by Reset.
    logic [31:0]       mem_q [DEPTH_WORDS] = '{default: '0};

    logic [IdxW-1:0]   req_idx;
    logic              req_bad;
    logic              acc_wr;
    logic [IdxW-1:0]   acc_idx;
    logic [31:0]       acc_wdata;
    logic [MemAw-1:0]  mem_addr;
    logic              mem_we;

    assign req_idx = Addr[ADDR_WIDTH-1:2];
    assign req_bad = (Addr[1:0] != 2'b00) || (32'(req_idx) >= DEPTH_WORDS);

    // With zero wait states RESP is entered straight from IDLE, so the access
    // must use the live request rather than the not-yet-latched copy.
    assign acc_wr    = (state_q == StIdle) ? Write      : wr_q;
    assign acc_idx   = (state_q == StIdle) ? req_idx    : idx_q;
    assign acc_wdata = (state_q == StIdle) ? Write_Data : wdata_q;
    assign mem_addr  = acc_idx[MemAw-1:0];

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        wr_d    = wr_q;
        idx_d   = idx_q;
        wdata_d = wdata_q;
        rdata_d = rdata_q;
        mem_we  = 1'b0;

        unique case (state_q)
            StIdle: begin
                if (Req) begin
                    wr_d    = Write;
                    idx_d   = req_idx;
                    wdata_d = Write_Data;
                    if (req_bad) begin
                        state_d = StErr;
                    end else if (WAIT_STATES == 0) begin
                        state_d = StResp;
                    end else begin
                        state_d = StWait;
                        cnt_d   = 4'(WAIT_STATES);
                    end
                end
            end
            StWait: begin
                cnt_d = cnt_q - 4'd1;
                if (cnt_q == 4'd1) begin
                    state_d = StResp;
                end
            end
            StResp:  state_d = StIdle;
            StErr:   state_d = StIdle;
            default: state_d = StIdle;
        endcase

        // The access itself happens on the edge that enters RESP.
        if (state_d == StResp) begin
            if (acc_wr) begin
                mem_we = ~Reset;
            end else begin
                rdata_d = mem_q[mem_addr];
            end
        end
        if (state_d == StErr) begin
            rdata_d = '0;
        end

        ack_d  = (state_d == StResp) || (state_d == StErr);
        busy_d = (state_d != StIdle);
        err_d  = (state_d == StErr);
    end

    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            state_q <= StIdle;
            cnt_q   <= '0;
            wr_q    <= 1'b0;
            idx_q   <= '0;
            wdata_q <= '0;
            ack_q   <= 1'b0;
            busy_q  <= 1'b0;
            err_q   <= 1'b0;
            rdata_q <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            wr_q    <= wr_d;
            idx_q   <= idx_d;
            wdata_q <= wdata_d;
            ack_q   <= ack_d;
            busy_q  <= busy_d;
            err_q   <= err_d;
            rdata_q <= rdata_d;
        end
    end

    always_ff @(posedge Clock) begin
        if (mem_we) begin
            mem_q[mem_addr] <= acc_wdata;
        end
    end

    assign Ack        = ack_q;
    assign Busy       = busy_q;
    assign Addr_Error = err_q;
    assign Read_Data  = rdata_q;

endmodule

// File: tb/tb_data_mem_responder.sv
module tb_data_mem_responder;

    logic        clk = 1'b0;
    logic        rst;
    logic [1:0]  req, wr, ack, busy, aerr;
    logic [12:0] addr  [2];
    logic [31:0] wdata [2];
    logic [31:0] rdata [2];
    int          total = 0;
    int          bad   = 0;
    int          cyc   = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Instance 0: default build. Instance 1: zero wait states, half-size array.
    data_mem_responder #(.ADDR_WIDTH(13), .DEPTH_WORDS(2048), .WAIT_STATES(2)) u_dut_ws2 (
        .Clock(clk), .Reset(rst), .Req(req[0]), .Write(wr[0]), .Addr(addr[0]),
        .Write_Data(wdata[0]), .Ack(ack[0]), .Read_Data(rdata[0]), .Busy(busy[0]),
        .Addr_Error(aerr[0])
    );

    data_mem_responder #(.ADDR_WIDTH(13), .DEPTH_WORDS(1024), .WAIT_STATES(0)) u_dut_ws0 (
        .Clock(clk), .Reset(rst), .Req(req[1]), .Write(wr[1]), .Addr(addr[1]),
        .Write_Data(wdata[1]), .Ack(ack[1]), .Read_Data(rdata[1]), .Busy(busy[1]),
        .Addr_Error(aerr[1])
    );

    // Reference model: plain word arrays plus the last value shown on Read_Data.
    int unsigned m_mem   [2][2048];
    logic [31:0] m_rd    [2];
    int unsigned m_ws    [2] = '{2, 0};
    int unsigned m_depth [2] = '{2048, 1024};

    function automatic void model(input int i, input bit w, input logic [12:0] a,
                                  input logic [31:0] d, output bit e,
                                  output logic [31:0] rd, output int lat);
        int unsigned idx;
        idx = 32'(a) >> 2;
        e   = (a[1:0] != 2'b00) || (idx >= m_depth[i]);
        if (e) begin
            m_rd[i] = '0;
            lat     = 1;
        end else begin
            lat = int'(m_ws[i]) + 1;
            if (w) m_mem[i][idx] = d;
            else   m_rd[i] = m_mem[i][idx];
        end
        rd = m_rd[i];
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", nm, act, exp);
        end
    endtask

    // Issue one request from an IDLE cycle and check the response.
    task automatic xact(input int i, input string nm, input bit w, input logic [12:0] a,
                        input logic [31:0] d, input bit e_exp, input logic [31:0] rd_exp,
                        input int lat_exp, input bit hold, output int at);
        int n;
        bit got;
        bit busy_ok;
        n = 0; got = 0; busy_ok = 1; at = -1;
        req[i] = 1'b1; wr[i] = w; addr[i] = a; wdata[i] = d;
        while (!got && n < 40) begin
            @(posedge clk); #1;
            n++;
            if (busy[i] !== 1'b1) busy_ok = 0;
            if (ack[i] === 1'b1) got = 1;
        end
        if (!hold) req[i] = 1'b0;
        if (!got) begin
            total++; bad++;
            $display("FAIL %s ack_timeout: no Ack within %0d cycles", nm, n);
        end else begin
            at = cyc;
            chk({nm, " latency"}, 32'(n), 32'(lat_exp));
            chk({nm, " addr_error"}, 32'(aerr[i]), 32'(e_exp));
            chk({nm, " read_data"}, rdata[i], rd_exp);
            chk({nm, " busy_while_pending"}, 32'(busy_ok), 32'd1);
        end
        @(posedge clk); #1;
        chk({nm, " idle_after_ack"}, {30'd0, ack[i], busy[i]}, 32'd0);
    endtask

    typedef struct {
        int          inst;
        bit          w;
        logic [12:0] a;
        logic [31:0] d;
        bit          e;
        logic [31:0] rd;
        int          lat;
    } vec_t;

    vec_t tbl [15];

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        bit          e;
        logic [31:0] rd;
        int          lat, at1, at2;
        bit          got;

        tbl[0]  = '{0, 1'b1, 13'h0010, 32'hDEADBEEF, 1'b0, 32'h00000000, 3};
        tbl[1]  = '{0, 1'b0, 13'h0010, 32'h00000000, 1'b0, 32'hDEADBEEF, 3};
        tbl[2]  = '{0, 1'b0, 13'h0013, 32'h00000000, 1'b1, 32'h00000000, 1};
        tbl[3]  = '{0, 1'b0, 13'h0010, 32'h00000000, 1'b0, 32'hDEADBEEF, 3};
        tbl[4]  = '{0, 1'b1, 13'h1FFC, 32'h12345678, 1'b0, 32'hDEADBEEF, 3};
        tbl[5]  = '{0, 1'b0, 13'h1FFC, 32'h00000000, 1'b0, 32'h12345678, 3};
        tbl[6]  = '{0, 1'b0, 13'h0002, 32'h00000000, 1'b1, 32'h00000000, 1};
        tbl[7]  = '{0, 1'b1, 13'h0011, 32'hFFFFFFFF, 1'b1, 32'h00000000, 1};
        tbl[8]  = '{0, 1'b0, 13'h0010, 32'h00000000, 1'b0, 32'hDEADBEEF, 3};
        tbl[9]  = '{0, 1'b0, 13'h00FC, 32'h00000000, 1'b0, 32'h00000000, 3};
        tbl[10] = '{1, 1'b0, 13'h0FFC, 32'h00000000, 1'b0, 32'h00000000, 1};
        tbl[11] = '{1, 1'b0, 13'h1000, 32'h00000000, 1'b1, 32'h00000000, 1};
        tbl[12] = '{1, 1'b1, 13'h0FFC, 32'hAAAA5555, 1'b0, 32'h00000000, 1};
        tbl[13] = '{1, 1'b0, 13'h0FFC, 32'h00000000, 1'b0, 32'hAAAA5555, 1};
        tbl[14] = '{1, 1'b0, 13'h1FFC, 32'h00000000, 1'b1, 32'h00000000, 1};

        rst = 1'b1; req = '0; wr = '0;
        addr[0] = '0; addr[1] = '0; wdata[0] = '0; wdata[1] = '0;
        m_rd[0] = '0; m_rd[1] = '0;
        repeat (2) @(posedge clk);
        #1;
        chk("reset ctl outputs", {26'd0, ack, busy, aerr}, 32'd0);
        chk("reset read_data0", rdata[0], 32'd0);
        chk("reset read_data1", rdata[1], 32'd0);
        rst = 1'b0;
        @(posedge clk); #1;

        for (int k = 0; k < 15; k++) begin
            model(tbl[k].inst, tbl[k].w, tbl[k].a, tbl[k].d, e, rd, lat);
            xact(tbl[k].inst, $sformatf("vec%0d", k), tbl[k].w, tbl[k].a, tbl[k].d,
                 tbl[k].e, tbl[k].rd, tbl[k].lat, 1'b0, at1);
        end

        // Back-to-back with Req held high across the Ack.
        model(0, 1'b1, 13'h020, 32'h11111111, e, rd, lat);
        xact(0, "b2b_store", 1'b1, 13'h020, 32'h11111111, e, rd, lat, 1'b1, at1);
        model(0, 1'b0, 13'h020, 32'h0, e, rd, lat);
        xact(0, "b2b_load", 1'b0, 13'h020, 32'h0, 1'b0, 32'h11111111, 3, 1'b0, at2);
        chk("b2b ack spacing", 32'(at2 - at1), 32'd4);

        // Asynchronous reset mid-cycle while a load is pending.
        req[0] = 1'b1; wr[0] = 1'b0; addr[0] = 13'h010;
        @(posedge clk); #1;
        chk("pre-reset busy", 32'(busy[0]), 32'd1);
        #3 rst = 1'b1;
        #1;
        chk("async reset ctl", {29'd0, ack[0], busy[0], aerr[0]}, 32'd0);
        chk("async reset read_data", rdata[0], 32'd0);
        for (int k = 0; k < 3; k++) begin
            @(posedge clk); #1;
            chk("held reset ignores req", {30'd0, ack[0], busy[0]}, 32'd0);
        end
        req[0] = 1'b0; rst = 1'b0;
        m_rd[0] = '0; m_rd[1] = '0;
        @(posedge clk); #1;

        // Reset during WAIT aborts the store.
        req[0] = 1'b1; wr[0] = 1'b1; addr[0] = 13'h040; wdata[0] = 32'hCAFEF00D;
        @(posedge clk); #1;
        #2 rst = 1'b1;
        #2 rst = 1'b0;
        req[0] = 1'b0;
        m_rd[0] = '0; m_rd[1] = '0;
        for (int k = 0; k < 3; k++) begin
            @(posedge clk); #1;
            chk("no ack after abort", 32'(ack[0]), 32'd0);
        end
        model(0, 1'b0, 13'h040, 32'h0, e, rd, lat);
        xact(0, "abort_load", 1'b0, 13'h040, 32'h0, 1'b0, 32'h00000000, 3, 1'b0, at1);

        // Reset during RESP: the committed store stands, Ack drops at once.
        model(0, 1'b1, 13'h044, 32'h5A5A0001, e, rd, lat);
        req[0] = 1'b1; wr[0] = 1'b1; addr[0] = 13'h044; wdata[0] = 32'h5A5A0001;
        got = 0;
        for (int k = 0; k < 10 && !got; k++) begin
            @(posedge clk); #1;
            if (ack[0] === 1'b1) got = 1;
        end
        chk("resp-reset got ack", 32'(got), 32'd1);
        #2 rst = 1'b1;
        #1;
        chk("ack drops on reset", 32'(ack[0]), 32'd0);
        #1 rst = 1'b0;
        req[0] = 1'b0;
        m_rd[0] = '0; m_rd[1] = '0;
        @(posedge clk); #1;
        model(0, 1'b0, 13'h044, 32'h0, e, rd, lat);
        xact(0, "resp_reset_load", 1'b0, 13'h044, 32'h0, 1'b0, 32'h5A5A0001, 3, 1'b0, at1);

        // Randomized traffic against the model.
        for (int k = 0; k < 300; k++) begin
            int          i;
            int          sel;
            bit          w;
            logic [12:0] a;
            logic [31:0] d;
            i   = $urandom_range(0, 1);
            w   = 1'($urandom_range(0, 1));
            sel = $urandom_range(0, 7);
            if (sel == 0)      a = 13'($urandom);
            else if (sel == 1) a = 13'(($urandom_range(0, 15) << 2) + $urandom_range(1, 3));
            else if (sel == 2) a = 13'($urandom_range(1020, 1027) << 2);
            else               a = 13'($urandom_range(0, 15) << 2);
            d = $urandom;
            model(i, w, a, d, e, rd, lat);
            xact(i, $sformatf("rnd%0d", k), w, a, d, e, rd, lat, 1'b0, at1);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
